id_ctrl_stage: RTL and testbench

Registered, handshaked successor of the combinational MIPS control decoder. It decodes a 32-bit instruction into the control bundle and holds it in the ID/EX pipeline register. It also adds multiply/divide (MDU) decode: a parametrised busy counter stalls dependent MDU instructions. It sits between the IF/ID register and the EX stage.

---
 rtl/ctrl_pkg.sv | 114 +++++++++++
 rtl/ctrl_decode.sv | 134 +++++++++++++
 rtl/id_ctrl_stage.sv | 118 +++++++++++
 tb/tb_id_ctrl_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the ID-stage control decoder: ALU/branch/load/store codes,
// MDU operation enum, opcode/funct constants and the packed control bundle.
package ctrl_pkg;

  localparam logic [3:0] ALU_SLTU = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_NOR  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_LUI  = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_SRL  = 4'd11;

  localparam logic [2:0] BR_EQ  = 3'd0;
  localparam logic [2:0] BR_GTZ = 3'd1;
  localparam logic [2:0] BR_GEZ = 3'd2;
  localparam logic [2:0] BR_LTZ = 3'd3;
  localparam logic [2:0] BR_LEZ = 3'd4;
  localparam logic [2:0] BR_NE  = 3'd5;

  localparam logic [2:0] LT_W  = 3'd0;
  localparam logic [2:0] LT_H  = 3'd1;
  localparam logic [2:0] LT_HU = 3'd2;
  localparam logic [2:0] LT_B  = 3'd3;
  localparam logic [2:0] LT_BU = 3'd4;

  localparam logic [1:0] ST_W = 2'd0;
  localparam logic [1:0] ST_H = 2'd1;
  localparam logic [1:0] ST_B = 2'd2;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MFHI  = 3'd5,
    MDU_MFLO  = 3'd6
  } mdu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef struct packed {
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic       reg_dst;
    logic       reg_write;
    logic       jump;
    logic       jump_r;
    logic       alu_a_src;
    logic [3:0] alu_ctrl;
    logic [2:0] branch_op;
    logic [2:0] load_type;
    logic [1:0] save_type;
  } ctrl_t;

  // Ops that actually occupy the multiply/divide unit (mfhi/mflo only read it).
  function automatic logic mdu_is_exec(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational MIPS instruction decoder: instr -> control bundle, MDU op, illegal flag.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit ENABLE_MDU = 1'b1
) (
  input  logic [31:0] i_instr,
  output ctrl_t       o_ctrl,
  output mdu_op_e     o_mdu_op,
  output logic        o_illegal
);

  logic [5:0] w_op;
  logic [4:0] w_rt;
  logic [5:0] w_funct;
  logic       w_ok;
  ctrl_t      w_ctrl;
  mdu_op_e    w_mdu;
  logic       w_unused;

  assign w_op     = i_instr[31:26];
  assign w_rt     = i_instr[20:16];
  assign w_funct  = i_instr[5:0];
  assign w_unused = ^{i_instr[25:21], i_instr[15:6]};

  always_comb begin
    w_ctrl = '0;
    w_mdu  = MDU_NONE;
    w_ok   = 1'b1;
    case (w_op)
      OP_RTYPE: begin
        w_ctrl.reg_dst   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        case (w_funct)
          FN_ADD, FN_ADDU: w_ctrl.alu_ctrl = ALU_ADD;
          FN_SUB, FN_SUBU: w_ctrl.alu_ctrl = ALU_SUB;
          FN_SLT:          w_ctrl.alu_ctrl = ALU_SLT;
          FN_SLTU:         w_ctrl.alu_ctrl = ALU_SLTU;
          FN_AND:          w_ctrl.alu_ctrl = ALU_AND;
          FN_OR:           w_ctrl.alu_ctrl = ALU_OR;
          FN_XOR:          w_ctrl.alu_ctrl = ALU_XOR;
          FN_NOR:          w_ctrl.alu_ctrl = ALU_NOR;
          FN_SLLV:         w_ctrl.alu_ctrl = ALU_SLL;
          FN_SRAV:         w_ctrl.alu_ctrl = ALU_SRA;
          FN_SRLV:         w_ctrl.alu_ctrl = ALU_SRL;
          FN_SLL: begin w_ctrl.alu_ctrl = ALU_SLL; w_ctrl.alu_a_src = 1'b1; end
          FN_SRL: begin w_ctrl.alu_ctrl = ALU_SRL; w_ctrl.alu_a_src = 1'b1; end
          FN_SRA: begin w_ctrl.alu_ctrl = ALU_SRA; w_ctrl.alu_a_src = 1'b1; end
          FN_JR: begin
            w_ctrl.reg_dst   = 1'b0;
            w_ctrl.reg_write = 1'b0;
            w_ctrl.jump      = 1'b1;
            w_ctrl.jump_r    = 1'b1;
            w_ctrl.branch    = 1'b1;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            // Results land in HI/LO, not the register file.
            w_ctrl.reg_dst   = 1'b0;
            w_ctrl.reg_write = 1'b0;
            case (w_funct)
              FN_MULT:  w_mdu = MDU_MULT;
              FN_MULTU: w_mdu = MDU_MULTU;
              FN_DIV:   w_mdu = MDU_DIV;
              default:  w_mdu = MDU_DIVU;
            endcase
            w_ok = ENABLE_MDU;
          end
          FN_MFHI: begin w_mdu = MDU_MFHI; w_ok = ENABLE_MDU; end
          FN_MFLO: begin w_mdu = MDU_MFLO; w_ok = ENABLE_MDU; end
          default: w_ok = 1'b0;
        endcase
      end
      OP_REGIMM: begin
        w_ctrl.branch = 1'b1;
        case (w_rt)
          5'd0:    w_ctrl.branch_op = BR_LTZ;
          5'd1:    w_ctrl.branch_op = BR_GEZ;
          default: w_ok = 1'b0;
        endcase
      end
      OP_J:    w_ctrl.jump = 1'b1;
      OP_BEQ:  begin w_ctrl.branch = 1'b1; w_ctrl.branch_op = BR_EQ;  end
      OP_BNE:  begin w_ctrl.branch = 1'b1; w_ctrl.branch_op = BR_NE;  end
      OP_BLEZ: begin w_ctrl.branch = 1'b1; w_ctrl.branch_op = BR_LEZ; end
      OP_BGTZ: begin w_ctrl.branch = 1'b1; w_ctrl.branch_op = BR_GTZ; end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LUI: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        case (w_op)
          OP_ANDI:  w_ctrl.alu_ctrl = ALU_AND;
          OP_ORI:   w_ctrl.alu_ctrl = ALU_OR;
          OP_XORI:  w_ctrl.alu_ctrl = ALU_XOR;
          OP_SLTI:  w_ctrl.alu_ctrl = ALU_SLT;
          OP_SLTIU: w_ctrl.alu_ctrl = ALU_SLTU;
          OP_LUI:   w_ctrl.alu_ctrl = ALU_LUI;
          default:  w_ctrl.alu_ctrl = ALU_ADD;
        endcase
      end
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.alu_ctrl   = ALU_ADD;
        case (w_op)
          OP_LH:   w_ctrl.load_type = LT_H;
          OP_LHU:  w_ctrl.load_type = LT_HU;
          OP_LB:   w_ctrl.load_type = LT_B;
          OP_LBU:  w_ctrl.load_type = LT_BU;
          default: w_ctrl.load_type = LT_W;
        endcase
      end
      OP_SW, OP_SH, OP_SB: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_ctrl  = ALU_ADD;
        case (w_op)
          OP_SH:   w_ctrl.save_type = ST_H;
          OP_SB:   w_ctrl.save_type = ST_B;
          default: w_ctrl.save_type = ST_W;
        endcase
      end
      default: w_ok = 1'b0;
    endcase
    if (!w_ok) begin
      w_ctrl = '0;
      w_mdu  = MDU_NONE;
    end
  end

  assign o_ctrl    = w_ctrl;
  assign o_mdu_op  = w_mdu;
  assign o_illegal = !w_ok;

endmodule

// File: rtl/id_ctrl_stage.sv
// ID/EX control register: decodes in_instr, holds one entry with valid/ready handshake,
// and stalls MDU-dependent instructions while the multiply/divide busy counter runs.
module id_ctrl_stage
  import ctrl_pkg::*;
#(
  parameter int MUL_LAT    = 4,
  parameter int DIV_LAT    = 32,
  parameter bit ENABLE_MDU = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        mem_to_reg,
  output logic        mem_write,
  output logic        branch,
  output logic        alu_src,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        jump,
  output logic        jump_r,
  output logic        alu_a_src,
  output logic [3:0]  alu_ctrl,
  output logic [2:0]  branch_op,
  output logic [2:0]  load_type,
  output logic [1:0]  save_type,
  output logic [2:0]  mdu_op,
  output logic        illegal,
  output logic        mdu_start,
  output logic        mdu_busy
);

  localparam int CW = $clog2(DIV_LAT + 1);
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);

  ctrl_t   w_dec_ctrl;
  mdu_op_e w_dec_mdu;
  logic    w_dec_illegal;

  logic    r_vld;
  ctrl_t   r_ctrl;
  mdu_op_e r_mdu;
  logic    r_illegal;
  logic [CW-1:0] r_cnt;

  logic w_hold;
  logic w_accept;
  logic w_fire;
  logic w_start;

  ctrl_decode #(.ENABLE_MDU(ENABLE_MDU)) u_decode (
    .i_instr   (in_instr),
    .o_ctrl    (w_dec_ctrl),
    .o_mdu_op  (w_dec_mdu),
    .o_illegal (w_dec_illegal)
  );

  // Any MDU op waits for the unit to drain, including one still sitting in this register.
  assign w_hold   = (w_dec_mdu != MDU_NONE) &&
                    ((r_cnt != '0) || (r_vld && mdu_is_exec(r_mdu)));
  assign in_ready = (!r_vld || out_ready) && !w_hold && !flush;
  assign w_accept = in_valid && in_ready;
  assign w_fire   = r_vld && out_ready && !flush;
  assign w_start  = w_fire && mdu_is_exec(r_mdu);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld     <= 1'b0;
      r_ctrl    <= '0;
      r_mdu     <= MDU_NONE;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_vld <= 1'b0;
    end else if (w_accept) begin
      r_vld     <= 1'b1;
      r_ctrl    <= w_dec_ctrl;
      r_mdu     <= w_dec_mdu;
      r_illegal <= w_dec_illegal;
    end else if (w_fire) begin
      r_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= ((r_mdu == MDU_DIV) || (r_mdu == MDU_DIVU)) ? DIV_CNT : MUL_CNT;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign out_valid  = r_vld;
  assign mem_to_reg = r_ctrl.mem_to_reg;
  assign mem_write  = r_ctrl.mem_write;
  assign branch     = r_ctrl.branch;
  assign alu_src    = r_ctrl.alu_src;
  assign reg_dst    = r_ctrl.reg_dst;
  assign reg_write  = r_ctrl.reg_write;
  assign jump       = r_ctrl.jump;
  assign jump_r     = r_ctrl.jump_r;
  assign alu_a_src  = r_ctrl.alu_a_src;
  assign alu_ctrl   = r_ctrl.alu_ctrl;
  assign branch_op  = r_ctrl.branch_op;
  assign load_type  = r_ctrl.load_type;
  assign save_type  = r_ctrl.save_type;
  assign mdu_op     = r_mdu;
  assign illegal    = r_illegal;
  assign mdu_start  = w_start;
  assign mdu_busy   = (r_cnt != '0);

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Directed bench for id_ctrl_stage: expectations queued at acceptance, checked on output handshake.
module tb_id_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        mem_to_reg, mem_write, branch, alu_src, reg_dst, reg_write;
  logic        jump, jump_r, alu_a_src;
  logic [3:0]  alu_ctrl;
  logic [2:0]  branch_op, load_type;
  logic [1:0]  save_type;
  logic [2:0]  mdu_op;
  logic        illegal, mdu_start, mdu_busy;

  id_ctrl_stage #(.MUL_LAT(4), .DIV_LAT(32), .ENABLE_MDU(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .mem_to_reg(mem_to_reg), .mem_write(mem_write), .branch(branch), .alu_src(alu_src),
    .reg_dst(reg_dst), .reg_write(reg_write), .jump(jump), .jump_r(jump_r),
    .alu_a_src(alu_a_src), .alu_ctrl(alu_ctrl), .branch_op(branch_op),
    .load_type(load_type), .save_type(save_type), .mdu_op(mdu_op), .illegal(illegal),
    .mdu_start(mdu_start), .mdu_busy(mdu_busy)
  );

  always #5 clk = ~clk;

  // Flag bits, order: mem_to_reg mem_write branch alu_src reg_dst reg_write jump jump_r alu_a_src
  localparam logic [8:0] M2R = 9'b100000000;
  localparam logic [8:0] MW  = 9'b010000000;
  localparam logic [8:0] BR  = 9'b001000000;
  localparam logic [8:0] AS  = 9'b000100000;
  localparam logic [8:0] RD  = 9'b000010000;
  localparam logic [8:0] RW  = 9'b000001000;
  localparam logic [8:0] JP  = 9'b000000100;
  localparam logic [8:0] JR  = 9'b000000010;
  localparam logic [8:0] AA  = 9'b000000001;

  logic [24:0] obs;
  assign obs = {mem_to_reg, mem_write, branch, alu_src, reg_dst, reg_write, jump, jump_r,
                alu_a_src, alu_ctrl, branch_op, load_type, save_type, mdu_op, illegal};

  int n_assert = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  int busy_cnt  = 0;
  logic [24:0] exp_q[$];

  function automatic logic [24:0] ex(input logic [8:0] f, input logic [3:0] alu,
                                     input logic [2:0] bop, input logic [2:0] lt,
                                     input logic [1:0] st, input logic [2:0] mdu,
                                     input logic ill);
    return {f, alu, bop, lt, st, mdu, ill};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd2, rt, 16'h1234};
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {6'h00, 5'd3, 5'd4, 5'd5, 5'd6, fn};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic send(input logic [31:0] ins, input logic [24:0] e, output int stalls);
    stalls   = 0;
    in_valid = 1'b1;
    in_instr = ins;
    @(negedge clk);
    while (!in_ready && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    else exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each output handshake consumes the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mdu_busy) busy_cnt++;
      if (mdu_start) begin
        start_cnt++;
        chk("start_while_busy", {31'd0, mdu_busy}, 32'd0);
      end
      if (out_valid && out_ready && !flush) begin
        n_assert++;
        assert (exp_q.size() > 0) else begin
          n_fail++;
          $error("FAIL unexpected_output: observed %0h expected none", obs);
        end
        if (exp_q.size() > 0) begin
          logic [24:0] e;
          e = exp_q.pop_front();
          chk("ctrl_bundle", {7'd0, obs}, {7'd0, e});
          chk("mdu_start", {31'd0, mdu_start},
              {31'd0, (e[3:1] >= 3'd1) && (e[3:1] <= 3'd4)});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int st;
    logic [24:0] e_add;
    e_add = ex(RD | RW, 4'd1, 3'd0, 3'd0, 2'd0, 3'd0, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_bundle", {7'd0, obs}, 32'd0);
    chk("rst_busy", {31'd0, mdu_busy}, 32'd0);
    chk("rst_start", {31'd0, mdu_start}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Stream with out_ready=1: one-cycle latency, one per cycle
    send(itype(6'h23, 5'd7), ex(M2R | AS | RW, 4'd1, 3'd0, 3'd0, 2'd0, 3'd0, 1'b0), st);
    @(negedge clk);
    chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    send(itype(6'h08, 5'd7), ex(AS | RW, 4'd1, 3'd0, 3'd0, 2'd0, 3'd0, 1'b0), st);
    chk("tput_addi", st, 0);
    send(itype(6'h2B, 5'd7), ex(MW | AS, 4'd1, 3'd0, 3'd0, 2'd0, 3'd0, 1'b0), st);
    chk("tput_sw", st, 0);
    send(itype(6'h04, 5'd7), ex(BR, 4'd0, 3'd0, 3'd0, 2'd0, 3'd0, 1'b0), st);
    chk("tput_beq", st, 0);
    send(rtype(6'h00), ex(RD | RW | AA, 4'd9, 3'd0, 3'd0, 2'd0, 3'd0, 1'b0), st);
    send(itype(6'h0F, 5'd7), ex(AS | RW, 4'd8, 3'd0, 3'd0, 2'd0, 3'd0, 1'b0), st);
    send(itype(6'h25, 5'd7), ex(M2R | AS | RW, 4'd1, 3'd0, 3'd2, 2'd0, 3'd0, 1'b0), st);
    send(itype(6'h28, 5'd7), ex(MW | AS, 4'd1, 3'd0, 3'd0, 2'd2, 3'd0, 1'b0), st);
    send(rtype(6'h08), ex(BR | JP | JR, 4'd0, 3'd0, 3'd0, 2'd0, 3'd0, 1'b0), st);
    send(itype(6'h02, 5'd0), ex(JP, 4'd0, 3'd0, 3'd0, 2'd0, 3'd0, 1'b0), st);
    idle(3);
    chk("stream_drained", exp_q.size(), 0);

    // Stall: add held with out_ready=0 for 3 cycles
    out_ready = 1'b0;
    send(rtype(6'h20), e_add, st);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_bundle", {7'd0, obs}, {7'd0, e_add});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(rtype(6'h22), ex(RD | RW, 4'd2, 3'd0, 3'd0, 2'd0, 3'd0, 1'b0), st);
    chk("resume_no_stall", st, 0);
    idle(3);
    chk("stall_drained", exp_q.size(), 0);
    chk("stall_no_dup_valid", {31'd0, out_valid}, 32'd0);

    // mult then mflo: mflo waits MUL_LAT+1 cycles after mult leaves
    busy_cnt = 0; start_cnt = 0;
    send(rtype(6'h18), ex(9'd0, 4'd0, 3'd0, 3'd0, 2'd0, 3'd1, 1'b0), st);
    send(rtype(6'h12), ex(RD | RW, 4'd0, 3'd0, 3'd0, 2'd0, 3'd6, 1'b0), st);
    chk("mflo_stall_cycles", st, 5);
    idle(4);
    chk("mult_busy_cycles", busy_cnt, 4);
    chk("mult_start_pulses", start_cnt, 1);

    // div then independent addu: addu not held, busy for DIV_LAT cycles
    busy_cnt = 0; start_cnt = 0;
    send(rtype(6'h1A), ex(9'd0, 4'd0, 3'd0, 3'd0, 2'd0, 3'd3, 1'b0), st);
    send(rtype(6'h21), ex(RD | RW, 4'd1, 3'd0, 3'd0, 2'd0, 3'd0, 1'b0), st);
    chk("addu_unstalled", st, 0);
    idle(40);
    chk("div_busy_cycles", busy_cnt, 32);
    chk("div_start_pulses", start_cnt, 1);

    // Flush a held mult, with a same-cycle handshake that flush must override
    busy_cnt = 0; start_cnt = 0;
    out_ready = 1'b0;
    send(rtype(6'h19), ex(9'd0, 4'd0, 3'd0, 3'd0, 2'd0, 3'd2, 1'b0), st);
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    chk("flush_no_start", {31'd0, mdu_start}, 32'd0);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_busy", {31'd0, mdu_busy}, 32'd0);
    idle(2);
    chk("flush_start_cnt", start_cnt, 0);
    chk("flush_busy_cnt", busy_cnt, 0);

    // Illegal encodings and REGIMM branches
    send(rtype(6'h3F), ex(9'd0, 4'd0, 3'd0, 3'd0, 2'd0, 3'd0, 1'b1), st);
    send(itype(6'h01, 5'd5), ex(9'd0, 4'd0, 3'd0, 3'd0, 2'd0, 3'd0, 1'b1), st);
    send(itype(6'h01, 5'd0), ex(BR, 4'd0, 3'd3, 3'd0, 2'd0, 3'd0, 1'b0), st);
    send(itype(6'h01, 5'd1), ex(BR, 4'd0, 3'd2, 3'd0, 2'd0, 3'd0, 1'b0), st);
    send(itype(6'h3F, 5'd0), ex(9'd0, 4'd0, 3'd0, 3'd0, 2'd0, 3'd0, 1'b1), st);
    idle(3);
    chk("illegal_drained", exp_q.size(), 0);

    // Asynchronous reset in the middle of a divide
    send(rtype(6'h1B), ex(9'd0, 4'd0, 3'd0, 3'd0, 2'd0, 3'd4, 1'b0), st);
    idle(5);
    chk("div_busy_before_rst", {31'd0, mdu_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, mdu_busy}, 32'd0);
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_busy", {31'd0, mdu_busy}, 32'd0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
